output_pipeline: RTL

OUTPUT_PIPELINE -- requirements
Module: output_pipeline

---
 rtl/output_pipeline.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/output_pipeline.sv
// Histogram-equalisation output stage: fetches 16-pixel words, remaps each pixel through the CDF table, writes them back.
// Define OUTPUT_PIPELINE_BYPASS_EN to copy pixels through unchanged with identical cycle timing.

module output_pipeline_lane (
  input  logic       clock,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_we,
  input  logic [7:0] i_d,
  output logic [7:0] o_q
);
  logic [7:0] r_q;

  always_ff @(posedge clock or posedge rst)
    if (rst)       r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_we)  r_q <= i_d;

  assign o_q = r_q;
endmodule

module output_pipeline #(
  parameter logic [14:0] ADDRESS_OF_LAST = 15'd3,
  parameter int          SCALE_SHIFT     = 24
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         start,
  input  logic         cdf_valid,
  input  logic [19:0]  cdf_min,
  input  logic [23:0]  scale_recip,
  input  logic         inputBaseOffset,
  input  logic         outputBaseOffset,
  output logic [15:0]  m3ReadAddr,
  input  logic [127:0] m3ReadBus,
  output logic [15:0]  m2ReadAddr,
  input  logic [127:0] m2ReadBus,
  output logic         m4WE,
  output logic [15:0]  m4WriteAddr,
  output logic [127:0] m4WriteBus,
  output logic         done,
  output logic         map_err
);
  localparam int NUM_LANES = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [2:0] {IDLE, FETCH, MAP, DRAIN, WRITE, DONE} state_t;

  state_t                      r_state, w_next;
  logic [14:0]                 r_word_cnt;
  logic [IDX_W-1:0]            r_k, r_m2_idx;
  logic                        r_drain, r_m2_vld, r_map_err;
  logic [NUM_LANES-1:0][7:0]   r_pix, w_m3_px, w_lanes;
  logic [7:0]                  w_lane_d;
  logic [15:0]                 w_m2_addr;
  logic                        w_bad, w_last, w_unused;

  assign w_m3_px = m3ReadBus;
  assign w_last  = (r_word_cnt == ADDRESS_OF_LAST);

`ifdef OUTPUT_PIPELINE_BYPASS_EN
  assign w_lane_d  = r_pix[r_m2_idx];
  assign w_bad     = 1'b0;
  assign w_m2_addr = '0;
  assign w_unused  = &{1'b0, m2ReadBus, cdf_min, scale_recip};
`else
  logic [15:0] w_tag;
  logic [19:0] w_cdf, w_diff;
  logic [43:0] w_prod;
  logic [44:0] w_rnd, w_q;
  logic [7:0]  w_sat, w_cur_px;

  assign w_tag  = m2ReadBus[35:20];
  assign w_cdf  = m2ReadBus[19:0];
  assign w_diff = w_cdf - cdf_min;
  assign w_prod = 44'(w_diff) * 44'(scale_recip);
  // Extra headroom bit so the rounding add cannot wrap a near-full product
  assign w_rnd  = {1'b0, w_prod} + (45'd1 << (SCALE_SHIFT - 1));
  assign w_q    = w_rnd >> SCALE_SHIFT;
  assign w_sat  = (|w_q[44:8]) ? 8'hFF : w_q[7:0];
  assign w_bad  = (w_tag != 16'hAAAA);
  assign w_lane_d = (w_bad || (w_cdf < cdf_min)) ? 8'h00 : w_sat;

  // Source word is on the bus only during MAP cycle 0; later pixels come from the captured copy
  assign w_cur_px  = (r_k == '0) ? w_m3_px[0] : r_pix[r_k];
  assign w_m2_addr = {8'h00, w_cur_px};
  assign w_unused  = &{1'b0, m2ReadBus[127:36]};
`endif

  always_ff @(posedge clock or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next      = r_state;
    m3ReadAddr  = '0;
    m2ReadAddr  = '0;
    m4WE        = 1'b0;
    m4WriteAddr = '0;
    done        = 1'b0;
    if (!start) w_next = IDLE;
    else begin
      case (r_state)
        IDLE:    if (cdf_valid) w_next = FETCH;
        FETCH:   w_next = MAP;
        MAP:     if (r_k == 4'd15) w_next = DRAIN;
        DRAIN:   if (r_drain) w_next = WRITE;
        WRITE:   w_next = w_last ? DONE : FETCH;
        DONE:    w_next = DONE;
        default: w_next = IDLE;
      endcase
    end
    case (r_state)
      FETCH: m3ReadAddr = {inputBaseOffset, r_word_cnt};
      MAP:   m2ReadAddr = w_m2_addr;
      WRITE: begin
        m4WE        = start;
        m4WriteAddr = {outputBaseOffset, r_word_cnt};
      end
      DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      r_word_cnt <= '0;
      r_k        <= '0;
      r_drain    <= 1'b0;
      r_m2_vld   <= 1'b0;
      r_m2_idx   <= '0;
      r_pix      <= '0;
    end else if (!start) begin
      r_word_cnt <= '0;
      r_k        <= '0;
      r_drain    <= 1'b0;
      r_m2_vld   <= 1'b0;
      r_m2_idx   <= '0;
      r_pix      <= '0;
    end else begin
      r_k      <= (r_state == MAP) ? r_k + 4'd1 : '0;
      r_drain  <= (r_state == DRAIN) ? ~r_drain : 1'b0;
      r_m2_vld <= (r_state == MAP);
      r_m2_idx <= r_k;
      if (r_state == MAP && r_k == '0) r_pix <= w_m3_px;
      if (r_state == WRITE && !w_last) r_word_cnt <= r_word_cnt + 15'd1;
    end

  always_ff @(posedge clock or posedge rst)
    if (rst)                                          r_map_err <= 1'b0;
    else if (r_state == IDLE && w_next == FETCH)      r_map_err <= 1'b0;
    else if (start && r_m2_vld && w_bad)              r_map_err <= 1'b1;

  assign map_err = r_map_err;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      output_pipeline_lane u_lane (
        .clock (clock),
        .rst   (rst),
        .i_clr (!start),
        .i_we  (r_m2_vld && (r_m2_idx == IDX_W'(gi))),
        .i_d   (w_lane_d),
        .o_q   (w_lanes[gi])
      );
    end
  endgenerate

  assign m4WriteBus = w_lanes;
endmodule
